// File: rtl/trb_mem_arbiter_pkg.sv
// Shared types and default sizing for the trace-buffer memory arbiter.
package DTB_PKG;

    localparam int TRB_DEPTH  = 16;
    localparam int TRB_WIDTH  = 8;
    localparam int ARB_PORT_W = 2;

    // Requester identity, used both for the round-robin winner and the read-pipeline tag.
    typedef enum logic [ARB_PORT_W-1:0] {
        ARB_LW = 2'd0,
        ARB_LR = 2'd1,
        ARB_H  = 2'd2
    } arb_port_e;

endpackage

// File: rtl/trb_mem_arbiter_rr.sv
// N-request round-robin arbiter: one-hot grant plus winner index; the port after
// the last winner has top priority, and the pointer only moves when something is granted.
module trb_rr_arbiter
    import DTB_PKG::*;
#(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic          CLK_I,
    input  logic          RST_NI,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] last_gnt_reg;
    logic [IW-1:0] rank [N];
    logic [N-1:0]  beats [N];

    // rank 0 is the port right after last_gnt_reg, i.e. the highest priority.
    for (genvar gi = 0; gi < N; gi++) begin : g_rank
        assign rank[gi] = IW'((gi + 2 * N - 1 - int'(last_gnt_reg)) % N);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        for (genvar gj = 0; gj < N; gj++) begin : g_beat
            assign beats[gi][gj] = req[gj] && (rank[gj] < rank[gi]);
        end
        assign gnt[gi] = req[gi] && !(|beats[gi]);
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

    assign gnt_any = |req;

    // Reset to the last port so that port 0 (logger write) wins first.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            last_gnt_reg <= IW'(N - 1);
        end else if (gnt_any) begin
            last_gnt_reg <= gnt_idx;
        end
    end

endmodule

// File: rtl/trb_mem_arbiter.sv
// Single-port trace-buffer RAM arbiter (logger write, logger read, debug host) with a
// two-cycle read-return pipeline. Host port present only when TRB_ARB_HOST_PORT_EN is defined.
module trb_mem_arbiter
    import DTB_PKG::*;
#(
    parameter int DEPTH = TRB_DEPTH,
    parameter int WIDTH = TRB_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             LW_REQ_I,
    input  logic [AW-1:0]    LW_ADDR_I,
    input  logic [WIDTH-1:0] LW_DATA_I,
    output logic             LW_GNT_O,
    input  logic             LR_REQ_I,
    input  logic [AW-1:0]    LR_ADDR_I,
    output logic             LR_GNT_O,
    output logic             LR_VALID_O,
    output logic [WIDTH-1:0] LR_DATA_O,
    input  logic             H_REQ_I,
    input  logic             H_WE_I,
    input  logic [AW-1:0]    H_ADDR_I,
    input  logic [WIDTH-1:0] H_DATA_I,
    output logic             H_GNT_O,
    output logic             H_VALID_O,
    output logic [WIDTH-1:0] H_DATA_O,
    output logic             MEM_EN_O,
    output logic             MEM_WE_O,
    output logic [AW-1:0]    MEM_ADDR_O,
    output logic [WIDTH-1:0] MEM_DATA_O,
    input  logic [WIDTH-1:0] MEM_DATA_I
);

`ifdef TRB_ARB_HOST_PORT_EN
    localparam int NPORT = 3;
`else
    localparam int NPORT = 2;
`endif
    localparam int IW = $clog2(NPORT);

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    arb_port_e        win_port;

    logic             s1_valid_reg;
    arb_port_e        s1_port_reg;
    logic             lr_valid_reg;
    logic [WIDTH-1:0] lr_data_reg;

`ifdef TRB_ARB_HOST_PORT_EN
    assign req = {H_REQ_I, LR_REQ_I, LW_REQ_I};
`else
    assign req = {LR_REQ_I, LW_REQ_I};
`endif

    trb_rr_arbiter #(.N(NPORT)) u_rr (
        .CLK_I   (CLK_I),
        .RST_NI  (RST_NI),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign win_port = arb_port_e'(ARB_PORT_W'(gnt_idx));
    assign LW_GNT_O = gnt[0];
    assign LR_GNT_O = gnt[1];

    always_comb begin
        MEM_EN_O   = gnt_any;
        MEM_WE_O   = 1'b0;
        MEM_ADDR_O = '0;
        MEM_DATA_O = '0;
        if (gnt_any) begin
            case (win_port)
                ARB_LW: begin
                    MEM_WE_O   = 1'b1;
                    MEM_ADDR_O = LW_ADDR_I;
                    MEM_DATA_O = LW_DATA_I;
                end
                ARB_LR: MEM_ADDR_O = LR_ADDR_I;
`ifdef TRB_ARB_HOST_PORT_EN
                ARB_H: begin
                    MEM_WE_O   = H_WE_I;
                    MEM_ADDR_O = H_ADDR_I;
                    MEM_DATA_O = H_DATA_I;
                end
`endif
                default: ;
            endcase
        end
    end

    // Stage 1 tags the read at grant; stage 2 steers the RAM output to its owner.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            s1_valid_reg <= 1'b0;
            s1_port_reg  <= ARB_LW;
            lr_valid_reg <= 1'b0;
            lr_data_reg  <= '0;
        end else begin
            s1_valid_reg <= gnt_any && !MEM_WE_O;
            s1_port_reg  <= win_port;
            lr_valid_reg <= s1_valid_reg && (s1_port_reg == ARB_LR);
            if (s1_valid_reg && (s1_port_reg == ARB_LR)) begin
                lr_data_reg <= MEM_DATA_I;
            end
        end
    end

    assign LR_VALID_O = lr_valid_reg;
    assign LR_DATA_O  = lr_data_reg;

`ifdef TRB_ARB_HOST_PORT_EN
    logic             h_valid_reg;
    logic [WIDTH-1:0] h_data_reg;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            h_valid_reg <= 1'b0;
            h_data_reg  <= '0;
        end else begin
            h_valid_reg <= s1_valid_reg && (s1_port_reg == ARB_H);
            if (s1_valid_reg && (s1_port_reg == ARB_H)) begin
                h_data_reg <= MEM_DATA_I;
            end
        end
    end

    assign H_GNT_O   = gnt[2];
    assign H_VALID_O = h_valid_reg;
    assign H_DATA_O  = h_data_reg;
`else
    logic unused_host;
    assign unused_host = ^{H_REQ_I, H_WE_I, H_ADDR_I, H_DATA_I};
    assign H_GNT_O     = 1'b0;
    assign H_VALID_O   = 1'b0;
    assign H_DATA_O    = '0;
`endif

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Directed bench for trb_mem_arbiter with a behavioural single-port RAM (one-cycle read).
module tb_trb_mem_arbiter;
    import DTB_PKG::*;

    localparam int AW = $clog2(TRB_DEPTH);
    localparam int W  = TRB_WIDTH;
`ifdef TRB_ARB_HOST_PORT_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif

    logic          CLK_I = 1'b0;
    logic          RST_NI;
    logic          LW_REQ_I, LR_REQ_I, H_REQ_I, H_WE_I;
    logic [AW-1:0] LW_ADDR_I, LR_ADDR_I, H_ADDR_I, MEM_ADDR_O;
    logic [W-1:0]  LW_DATA_I, H_DATA_I, LR_DATA_O, H_DATA_O, MEM_DATA_O;
    logic [W-1:0]  MEM_DATA_I = '0;
    logic          LW_GNT_O, LR_GNT_O, LR_VALID_O, H_GNT_O, H_VALID_O, MEM_EN_O, MEM_WE_O;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ram [TRB_DEPTH];

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        if (MEM_EN_O) begin
            if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_DATA_O;
            else          MEM_DATA_I <= ram[MEM_ADDR_O];
        end
    end

    trb_mem_arbiter dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI),
        .LW_REQ_I(LW_REQ_I), .LW_ADDR_I(LW_ADDR_I), .LW_DATA_I(LW_DATA_I), .LW_GNT_O(LW_GNT_O),
        .LR_REQ_I(LR_REQ_I), .LR_ADDR_I(LR_ADDR_I), .LR_GNT_O(LR_GNT_O),
        .LR_VALID_O(LR_VALID_O), .LR_DATA_O(LR_DATA_O),
        .H_REQ_I(H_REQ_I), .H_WE_I(H_WE_I), .H_ADDR_I(H_ADDR_I), .H_DATA_I(H_DATA_I),
        .H_GNT_O(H_GNT_O), .H_VALID_O(H_VALID_O), .H_DATA_O(H_DATA_O),
        .MEM_EN_O(MEM_EN_O), .MEM_WE_O(MEM_WE_O), .MEM_ADDR_O(MEM_ADDR_O),
        .MEM_DATA_O(MEM_DATA_O), .MEM_DATA_I(MEM_DATA_I)
    );

    task automatic next_cycle();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic clear_inputs();
        LW_REQ_I = 1'b0; LW_ADDR_I = '0; LW_DATA_I = '0;
        LR_REQ_I = 1'b0; LR_ADDR_I = '0;
        H_REQ_I  = 1'b0; H_WE_I = 1'b0; H_ADDR_I = '0; H_DATA_I = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST_NI = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1 RST_NI = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        clear_inputs();
        RST_NI = 1'b0;
        @(negedge CLK_I);
        obs = {MEM_EN_O, MEM_WE_O, LW_GNT_O, LR_GNT_O, H_GNT_O, LR_VALID_O, H_VALID_O,
               9'(LR_DATA_O | H_DATA_O)};
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL reset_in obs=%h exp=0000", obs);
        end
        @(posedge CLK_I);
        #1 RST_NI = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK_I);
            obs = {MEM_EN_O, MEM_WE_O, LW_GNT_O, LR_GNT_O, H_GNT_O, LR_VALID_O, H_VALID_O,
                   9'(LR_DATA_O | H_DATA_O)};
            checks++;
            if (obs !== 16'h0) begin
                failures++;
                $display("FAIL reset_idle c=%0d obs=%h exp=0000", c, obs);
            end
        end
    endtask

    task automatic test_write_read();
        next_cycle();
        LW_REQ_I = 1'b1; LW_ADDR_I = AW'(3); LW_DATA_I = 8'hA5;
        @(negedge CLK_I);
        checks++;
        if ({LW_GNT_O, LR_GNT_O, H_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O}
                !== {5'b10011, AW'(3), 8'hA5}) begin
            failures++;
            $display("FAIL lw_write gnt=%b%b%b en=%b we=%b addr=%0d data=%h exp gnt=100 en=1 we=1 addr=3 data=a5",
                     LW_GNT_O, LR_GNT_O, H_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O);
        end
        next_cycle();
        LW_REQ_I = 1'b0; LR_REQ_I = 1'b1; LR_ADDR_I = AW'(3);
        @(negedge CLK_I);
        checks++;
        if ({LW_GNT_O, LR_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O} !== {4'b0110, AW'(3)}) begin
            failures++;
            $display("FAIL lr_issue lw_gnt=%b lr_gnt=%b en=%b we=%b addr=%0d exp 0 1 1 0 3",
                     LW_GNT_O, LR_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O);
        end
        next_cycle();
        LR_REQ_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if (LR_VALID_O !== 1'b0) begin
            failures++;
            $display("FAIL lr_t1 valid=%b exp=0", LR_VALID_O);
        end
        next_cycle();
        @(negedge CLK_I);
        checks++;
        if ({LR_VALID_O, LR_DATA_O} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL lr_t2 valid=%b data=%h exp valid=1 data=a5", LR_VALID_O, LR_DATA_O);
        end
        next_cycle();
        @(negedge CLK_I);
        checks++;
        if ({LR_VALID_O, LR_DATA_O} !== {1'b0, 8'hA5}) begin
            failures++;
            $display("FAIL lr_hold valid=%b data=%h exp valid=0 data=a5", LR_VALID_O, LR_DATA_O);
        end
    endtask

    task automatic test_pipelined();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            LW_REQ_I = 1'b1; LW_ADDR_I = AW'(8 + i); LW_DATA_I = W'(8'h10 + i);
        end
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            LW_REQ_I = 1'b0;
            LR_REQ_I = (k < 4);
            LR_ADDR_I = AW'(8 + (k % 4));
            @(negedge CLK_I);
            checks++;
            if (LR_GNT_O !== (k < 4)) begin
                failures++;
                $display("FAIL pipe_gnt k=%0d got=%b exp=%b", k, LR_GNT_O, (k < 4));
            end
            checks++;
            if (LR_VALID_O !== (k >= 2)) begin
                failures++;
                $display("FAIL pipe_valid k=%0d got=%b exp=%b", k, LR_VALID_O, (k >= 2));
            end
            if (k >= 2) begin
                checks++;
                if (LR_DATA_O !== W'(8'h10 + k - 2)) begin
                    failures++;
                    $display("FAIL pipe_data k=%0d got=%h exp=%h", k, LR_DATA_O, W'(8'h10 + k - 2));
                end
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [2:0]    exp_gnt;
        logic [AW-1:0] exp_addr;
        int            idx;
        do_reset();
        next_cycle();
        LW_REQ_I = 1'b1; LW_ADDR_I = AW'(1); LW_DATA_I = 8'h55;
        LR_REQ_I = 1'b1; LR_ADDR_I = AW'(2);
        H_REQ_I  = 1'b1; H_WE_I = 1'b0; H_ADDR_I = AW'(4);
        for (int c = 0; c < 6; c++) begin
            idx = c % NP;
            exp_gnt  = 3'b001 << idx;
            exp_addr = (idx == 0) ? AW'(1) : (idx == 1) ? AW'(2) : AW'(4);
            @(negedge CLK_I);
            checks++;
            if ({H_GNT_O, LR_GNT_O, LW_GNT_O} !== exp_gnt) begin
                failures++;
                $display("FAIL rr_gnt c=%0d got(h,lr,lw)=%b exp=%b", c, {H_GNT_O, LR_GNT_O, LW_GNT_O}, exp_gnt);
            end
            checks++;
            if ({MEM_EN_O, MEM_WE_O, MEM_ADDR_O} !== {1'b1, (idx == 0), exp_addr}) begin
                failures++;
                $display("FAIL rr_mem c=%0d en=%b we=%b addr=%0d exp en=1 we=%b addr=%0d",
                         c, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, (idx == 0), exp_addr);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_host();
        int nvalid;
        int lr_hits;
        do_reset();
`ifdef TRB_ARB_HOST_PORT_EN
        next_cycle();
        H_REQ_I = 1'b1; H_WE_I = 1'b1; H_ADDR_I = AW'(7); H_DATA_I = 8'h3C;
        @(negedge CLK_I);
        checks++;
        if ({H_GNT_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O} !== {2'b11, AW'(7), 8'h3C}) begin
            failures++;
            $display("FAIL h_write gnt=%b we=%b addr=%0d data=%h exp 1 1 7 3c",
                     H_GNT_O, MEM_WE_O, MEM_ADDR_O, MEM_DATA_O);
        end
        next_cycle();
        H_WE_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if ({H_GNT_O, MEM_WE_O, H_VALID_O} !== 3'b100) begin
            failures++;
            $display("FAIL h_read gnt=%b we=%b valid=%b exp 1 0 0", H_GNT_O, MEM_WE_O, H_VALID_O);
        end
        next_cycle();
        H_REQ_I = 1'b0;
        nvalid = 0; lr_hits = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK_I);
            if (H_VALID_O) nvalid++;
            if (LR_VALID_O) lr_hits++;
            if (c == 2) begin
                checks++;
                if ({H_VALID_O, H_DATA_O} !== {1'b1, 8'h3C}) begin
                    failures++;
                    $display("FAIL h_data valid=%b data=%h exp valid=1 data=3c", H_VALID_O, H_DATA_O);
                end
            end
            next_cycle();
        end
        checks++;
        if (nvalid != 1 || lr_hits != 0) begin
            failures++;
            $display("FAIL h_valid_count h_valid=%0d lr_valid=%0d exp 1 and 0", nvalid, lr_hits);
        end
`else
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            H_REQ_I = 1'b1; H_WE_I = (c < 3); H_ADDR_I = AW'(7); H_DATA_I = 8'h3C;
            @(negedge CLK_I);
            checks++;
            if ({H_GNT_O, MEM_EN_O, H_VALID_O, H_DATA_O} !== 11'h0) begin
                failures++;
                $display("FAIL h_ignored c=%0d gnt=%b en=%b valid=%b data=%h exp all 0",
                         c, H_GNT_O, MEM_EN_O, H_VALID_O, H_DATA_O);
            end
        end
        nvalid = 0; lr_hits = 0;
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        next_cycle();
        LR_REQ_I = 1'b1; LR_ADDR_I = AW'(3);
        next_cycle();
        LR_REQ_I = 1'b0;
        next_cycle();
        @(negedge CLK_I);
        checks++;
        if ({LR_VALID_O, LR_DATA_O} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL mid_pre valid=%b data=%h exp valid=1 data=a5", LR_VALID_O, LR_DATA_O);
        end
        next_cycle();
        LR_REQ_I = 1'b1; LR_ADDR_I = AW'(3);
        @(negedge CLK_I);
        checks++;
        if (LR_GNT_O !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt got=%b exp=1", LR_GNT_O);
        end
        next_cycle();
        LR_REQ_I = 1'b0;
        RST_NI = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1 RST_NI = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK_I);
            checks++;
            if ({LR_VALID_O, LR_DATA_O} !== {1'b0, 8'h00}) begin
                failures++;
                $display("FAIL mid_after c=%0d valid=%b data=%h exp valid=0 data=00", c, LR_VALID_O, LR_DATA_O);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < TRB_DEPTH; i++) ram[i] = '0;
        clear_inputs();
        RST_NI = 1'b0;
        test_reset();
        test_write_read();
        test_pipelined();
        test_round_robin();
        test_host();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
